// File: rtl/datapath_seq_pkg.sv
// Shared types and constants for the sequenced datapath.
package datapath_seq_pkg;

  typedef enum logic [2:0] {
    OP_MOV  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_CMP  = 3'd3,
    OP_AND  = 3'd4,
    OP_MVN  = 3'd5,
    OP_MUL  = 3'd6,
    OP_MOV7 = 3'd7   // reserved encoding, behaves as MOV
  } opcode_e;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_MUL  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  // status = {N,Z,V,C}
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_V = 1;
  localparam int ST_C = 0;

  // MOV-class ops take only the B operand; A is forced to zero.
  function automatic logic is_mov_like(input opcode_e op);
    return (op == OP_MOV) || (op == OP_MVN) || (op == OP_MOV7);
  endfunction

endpackage

// File: rtl/datapath_seq_regfile.sv
// Register file: two write ports (port A wins on collision), one operand
// read port and one debug read port, both combinational.
module regfile_param #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [NREG-1:0][DW-1:0] regs;

  function automatic logic in_rng(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  // Low-priority port first so the high-priority write lands last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (wb_en && in_rng(wb_addr)) regs[wb_addr] <= wb_data;
      if (wa_en && in_rng(wa_addr)) regs[wa_addr] <= wa_data;
    end
  end

  // Out-of-range indices read as zero.
  always_comb begin
    rd_data  = in_rng(rd_addr)  ? regs[rd_addr]  : '0;
    dbg_data = in_rng(dbg_addr) ? regs[dbg_addr] : '0;
  end

endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle register/ALU datapath: fetch A, fetch B, execute (or
// iterative shift-add multiply), write back.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rn,
  input  logic [AW-1:0] rm,
  input  logic [1:0]    shift,
  input  logic          use_imm,
  input  logic [DW-1:0] imm,
  input  logic          write_en,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          done,
  output logic [DW-1:0] result,
  output logic [3:0]    status
);

  localparam int CW = $clog2(DW + 1);

  typedef struct packed {
    opcode_e       opcode;
    logic [AW-1:0] rd;
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    logic [1:0]    shift;
    logic          use_imm;
    logic [DW-1:0] imm;
    logic          write_en;
  } op_req_t;

  state_e        state_q, state_d;
  op_req_t       op_q;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [3:0]    st_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  logic          accept, mul_last, wb_we;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] b_sh, aop, bop, alu_c, mul_acc;
  logic [DW:0]   add_w, sub_w;
  logic          alu_v, alu_cy;

  assign op_ready = (state_q == S_IDLE);
  assign accept   = op_valid && op_ready;
  assign mul_last = (cnt_q == CW'(DW - 1));
  assign wb_we    = (state_q == S_WB) && op_q.write_en && (op_q.opcode != OP_CMP);
  assign rf_raddr = (state_q == S_RD_A) ? op_q.rn : op_q.rm;
  assign done     = done_q;
  assign result   = c_q;
  assign status   = st_q;

  regfile_param #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wa_en    (wb_we),
    .wa_addr  (op_q.rd),
    .wa_data  (c_q),
    .wb_en    (ext_we),
    .wb_addr  (ext_addr),
    .wb_data  (ext_data),
    .rd_addr  (rf_raddr),
    .rd_data  (rf_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RD_A;
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = (op_q.opcode == OP_MUL) ? S_MUL : S_WB;
      S_MUL:   if (mul_last) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand shaping, ALU and one multiply step.
  always_comb begin
    case (op_q.shift)
      SH_LSL1: b_sh = {b_q[DW-2:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b_q[DW-1:1]};
      SH_ASR1: b_sh = {b_q[DW-1], b_q[DW-1:1]};
      default: b_sh = b_q;
    endcase
    bop   = op_q.use_imm ? op_q.imm : b_sh;
    aop   = is_mov_like(op_q.opcode) ? '0 : a_q;
    add_w = {1'b0, aop} + {1'b0, bop};
    // carry-out of a + ~b + 1 is the not-borrow flag
    sub_w = {1'b0, aop} + {1'b0, ~bop} + (DW+1)'(1);
    alu_c  = bop;
    alu_v  = 1'b0;
    alu_cy = 1'b0;
    case (op_q.opcode)
      OP_ADD: begin
        alu_c  = add_w[DW-1:0];
        alu_cy = add_w[DW];
        alu_v  = (aop[DW-1] == bop[DW-1]) && (add_w[DW-1] != aop[DW-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_c  = sub_w[DW-1:0];
        alu_cy = sub_w[DW];
        alu_v  = (aop[DW-1] != bop[DW-1]) && (sub_w[DW-1] != aop[DW-1]);
      end
      OP_AND:  alu_c = aop & bop;
      OP_MVN:  alu_c = ~bop;
      default: alu_c = bop;
    endcase
    mul_acc = c_q + (b_q[0] ? a_q : '0);
  end

  // Operation capture, operand/result registers, multiply iteration, done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      st_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q.opcode   <= opcode_e'(opcode);
        op_q.rd       <= rd;
        op_q.rn       <= rn;
        op_q.rm       <= rm;
        op_q.shift    <= shift;
        op_q.use_imm  <= use_imm;
        op_q.imm      <= imm;
        op_q.write_en <= write_en;
      end
      case (state_q)
        S_RD_A: a_q <= rf_rdata;
        S_RD_B: b_q <= rf_rdata;
        S_EXEC: begin
          if (op_q.opcode == OP_MUL) begin
            // a_q becomes the multiplicand, b_q the multiplier
            c_q   <= '0;
            b_q   <= bop;
            cnt_q <= '0;
          end else begin
            c_q        <= alu_c;
            st_q[ST_N] <= alu_c[DW-1];
            st_q[ST_Z] <= (alu_c == '0);
            st_q[ST_V] <= alu_v;
            st_q[ST_C] <= alu_cy;
          end
        end
        S_MUL: begin
          c_q   <= mul_acc;
          a_q   <= {a_q[DW-2:0], 1'b0};
          b_q   <= {1'b0, b_q[DW-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (mul_last) begin
            st_q[ST_N] <= mul_acc[DW-1];
            st_q[ST_Z] <= (mul_acc == '0);
            st_q[ST_V] <= 1'b0;
            st_q[ST_C] <= 1'b0;
          end
        end
        default: ;
      endcase
      done_q <= (state_d == S_WB);
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: vector table plus corner sequences.
module tb_datapath_seq;

  localparam int DW = 16;
  localparam int NREG = 8;
  localparam int AW = 3;
  localparam logic [15:0] PRESET = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid, op_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] rd, rn, rm;
  logic [1:0]    shift;
  logic          use_imm;
  logic [DW-1:0] imm;
  logic          write_en;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_data;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          done;
  logic [DW-1:0] result;
  logic [3:0]    status;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd, rn, rm;
    logic [1:0]  sh;
    logic        ui;
    logic [15:0] imm;
    logic        we;
    logic [15:0] rnv, rmv;
    logic [15:0] c;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] c;
    logic [3:0]  st;
    logic [15:0] rdv;
    int          lat;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  datapath_seq #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .shift(shift),
    .use_imm(use_imm), .imm(imm), .write_en(write_en), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_data(ext_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .done(done), .result(result), .status(status)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] rd_i,
      input logic [1:0] sh, input logic ui, input logic [15:0] im, input logic we,
      input logic [15:0] rnv, input logic [15:0] rmv, input logic [15:0] c,
      input logic [3:0] st, input int lat);
    vec_t v;
    v.op = op; v.rd = rd_i; v.rn = 3'd1; v.rm = 3'd2; v.sh = sh; v.ui = ui;
    v.imm = im; v.we = we; v.rnv = rnv; v.rmv = rmv; v.c = c; v.st = st; v.lat = lat;
    return v;
  endfunction

  // mode 0: plain; 1: pulse op_valid mid-operation; 2: ext write to rd during WB
  task automatic do_op(input vec_t v, input int mode);
    exp_t e, got;
    int cyc;
    logic [15:0] rv;
    ext_write(v.rd, PRESET);
    ext_write(v.rn, v.rnv);
    ext_write(v.rm, v.rmv);
    opcode = v.op; rd = v.rd; rn = v.rn; rm = v.rm; shift = v.sh;
    use_imm = v.ui; imm = v.imm; write_en = v.we; op_valid = 1'b1;
    check("ready_idle", op_ready, 1);
    e.c = v.c; e.st = v.st; e.lat = v.lat;
    e.rdv = (v.we && v.op != 3'd3) ? v.c : PRESET;
    if (mode == 2) e.rdv = v.c;
    sb.push_back(e);
    tick();
    // scramble the inputs: the op must have been captured on the accept edge
    op_valid = 1'b0; opcode = 3'd4; imm = 16'h0; shift = 2'b00; use_imm = 1'b0;
    rd = 3'd7; rn = 3'd7; rm = 3'd7;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (mode == 1 && cyc == 8) begin
        op_valid = 1'b1;
        check("ready_busy", op_ready, 0);
      end else begin
        op_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    op_valid = 1'b0;
    check("done_seen", done, 1);
    if (done && sb.size() > 0) begin
      got = sb.pop_front();
      check("latency", cyc, got.lat);
      check("result", result, got.c);
      check("status", status, got.st);
      if (mode == 2) begin
        ext_we = 1'b1; ext_addr = v.rd; ext_data = 16'hDEAD;
      end
      tick();
      ext_we = 1'b0;
      check("done_pulse", done, 0);
      check("ready_after", op_ready, 1);
      read_reg(v.rd, rv);
      check("rd_value", rv, got.rdv);
    end
  endtask

  initial begin
    logic [15:0] rv;
    int seen_done, seen_busy;
    rst_n = 1'b0; op_valid = 1'b0; opcode = '0; rd = '0; rn = '0; rm = '0;
    shift = '0; use_imm = 1'b0; imm = '0; write_en = 1'b0; ext_we = 1'b0;
    ext_addr = '0; ext_data = '0; dbg_addr = '0;
    tick(); tick();
    check("rst_ready", op_ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    read_reg(3'd1, rv);
    check("rst_r1", rv, 0);
    rst_n = 1'b1;
    tick();

    //        op    rd    sh     ui  imm       we  rnv       rmv       c         st       lat
    vt.push_back(mk(3'd1, 3'd3, 2'b00, 0, 16'h0000, 1, 16'h0005, 16'h0003, 16'h0008, 4'b0000, 4));
    vt.push_back(mk(3'd1, 3'd3, 2'b00, 0, 16'h0000, 1, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 4));
    vt.push_back(mk(3'd3, 3'd5, 2'b00, 0, 16'h0000, 1, 16'h0009, 16'h0009, 16'h0000, 4'b0101, 4));
    vt.push_back(mk(3'd2, 3'd3, 2'b00, 0, 16'h0000, 1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000, 4));
    vt.push_back(mk(3'd2, 3'd3, 2'b00, 0, 16'h0000, 1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 4));
    vt.push_back(mk(3'd4, 3'd3, 2'b00, 0, 16'h0000, 1, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 4));
    vt.push_back(mk(3'd5, 3'd3, 2'b00, 0, 16'h0000, 1, 16'h1234, 16'h00FF, 16'hFF00, 4'b1000, 4));
    vt.push_back(mk(3'd0, 3'd3, 2'b11, 1, 16'hFFF0, 1, 16'h1234, 16'h0001, 16'hFFF0, 4'b1000, 4));
    vt.push_back(mk(3'd0, 3'd3, 2'b01, 0, 16'h0000, 1, 16'h1234, 16'h4001, 16'h8002, 4'b1000, 4));
    vt.push_back(mk(3'd0, 3'd3, 2'b10, 0, 16'h0000, 1, 16'h1234, 16'h8003, 16'h4001, 4'b0000, 4));
    vt.push_back(mk(3'd0, 3'd3, 2'b11, 0, 16'h0000, 1, 16'h1234, 16'h8003, 16'hC001, 4'b1000, 4));
    vt.push_back(mk(3'd1, 3'd3, 2'b00, 0, 16'h0000, 1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 4));
    vt.push_back(mk(3'd1, 3'd3, 2'b00, 1, 16'hFFFF, 1, 16'h0010, 16'h0001, 16'h000F, 4'b0001, 4));
    vt.push_back(mk(3'd7, 3'd3, 2'b00, 0, 16'h0000, 1, 16'h1111, 16'h2222, 16'h2222, 4'b0000, 4));
    vt.push_back(mk(3'd0, 3'd3, 2'b00, 0, 16'h0000, 0, 16'h1111, 16'h0042, 16'h0042, 4'b0000, 4));
    vt.push_back(mk(3'd2, 3'd3, 2'b01, 0, 16'h0000, 1, 16'h0010, 16'h0004, 16'h0008, 4'b0001, 4));
    foreach (vt[i]) do_op(vt[i], 0);

    // multiply 300*7 with a stray request while busy
    do_op(mk(3'd6, 3'd3, 2'b00, 0, 16'h0000, 1, 16'd300, 16'd7, 16'd2100, 4'b0000, 20), 1);
    // writeback and external write collide on R4
    do_op(mk(3'd1, 3'd4, 2'b00, 0, 16'h0000, 1, 16'h0100, 16'h0023, 16'h0123, 4'b0000, 4), 2);

    // reset while in EXEC, with ext write and request held during reset
    ext_write(3'd1, 16'd5);
    ext_write(3'd2, 16'd3);
    opcode = 3'd1; rd = 3'd3; rn = 3'd1; rm = 3'd2; shift = 2'b00;
    use_imm = 1'b0; write_en = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0; ext_we = 1'b1; ext_addr = 3'd6; ext_data = 16'h7777; op_valid = 1'b1;
    tick();
    check("rstx_ready", op_ready, 1);
    check("rstx_done", done, 0);
    check("rstx_result", result, 0);
    check("rstx_status", status, 0);
    for (int i = 0; i < NREG; i++) begin
      read_reg(3'(i), rv);
      check($sformatf("rstx_r%0d", i), rv, 0);
    end
    rst_n = 1'b1; ext_we = 1'b0; op_valid = 1'b0;
    seen_done = 0; seen_busy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen_done++;
      if (!op_ready) seen_busy++;
    end
    check("rstx_no_done", seen_done, 0);
    check("rstx_idle", seen_busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
